// File: rtl/mux4_to_1_pkg.sv
// Shared constants for the 4:1 mux: select codes and the default data width.
package mux4_to_1_pkg;

  localparam logic [1:0] SEL_I0 = 2'b00;
  localparam logic [1:0] SEL_I1 = 2'b01;
  localparam logic [1:0] SEL_I2 = 2'b10;
  localparam logic [1:0] SEL_I3 = 2'b11;

  localparam int unsigned DEFAULT_WIDTH = 1;

endpackage

// File: rtl/mux2_to_1.sv
// Bitwise 2:1 multiplexer; the building block of mux4_to_1.
module mux2_to_1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux4_to_1.sv
// 4:1 mux built from three 2:1 stages, with a registered copy of the output.
// Optional build macro MUX4_TO_1_HOLD_EN adds input en to gate the output register.
module mux4_to_1
  import mux4_to_1_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
`ifdef MUX4_TO_1_HOLD_EN
  input  logic             en,
`endif
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q
);

  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] r_y_q;

  // Level 1 splits on sel[0]; level 2 chooses the pair with sel[1].
  mux2_to_1 #(.WIDTH(WIDTH)) u_mux_lo (
    .a (i0),
    .b (i1),
    .s (sel[0]),
    .y (w_lo)
  );

  mux2_to_1 #(.WIDTH(WIDTH)) u_mux_hi (
    .a (i2),
    .b (i3),
    .s (sel[0]),
    .y (w_hi)
  );

  mux2_to_1 #(.WIDTH(WIDTH)) u_mux_out (
    .a (w_lo),
    .b (w_hi),
    .s (sel[1]),
    .y (y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_q <= '0;
`ifdef MUX4_TO_1_HOLD_EN
    end else if (en) begin
`else
    end else begin
`endif
      r_y_q <= y;
    end
  end

  assign y_q = r_y_q;

endmodule

// File: tb/tb_mux4_to_1.sv
// Self-checking bench: WIDTH=1 and WIDTH=8 instances against an array-indexing reference model.
module tb_mux4_to_1;

`ifdef MUX4_TO_1_HOLD_EN
  localparam bit HasEn = 1'b1;
`else
  localparam bit HasEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] sel;
  logic       a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;
  logic       y1, y1_q;
  logic [7:0] y8, y8_q;

  logic [7:0] exp_q1, exp_q8;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  mux4_to_1 #(.WIDTH(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
`ifdef MUX4_TO_1_HOLD_EN
    .en  (en),
`endif
    .i0  (a0),
    .i1  (a1),
    .i2  (a2),
    .i3  (a3),
    .sel (sel),
    .y   (y1),
    .y_q (y1_q)
  );

  mux4_to_1 #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
`ifdef MUX4_TO_1_HOLD_EN
    .en  (en),
`endif
    .i0  (b0),
    .i1  (b1),
    .i2  (b2),
    .i3  (b3),
    .sel (sel),
    .y   (y8),
    .y_q (y8_q)
  );

  function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] d0, d1, d2, d3);
    logic [7:0] t [4];
    t = '{d0, d1, d2, d3};
    return t[s];
  endfunction

  function automatic logic [7:0] ref1();
    return pick(sel, {7'b0, a0}, {7'b0, a1}, {7'b0, a2}, {7'b0, a3});
  endfunction

  function automatic logic [7:0] ref8();
    return pick(sel, b0, b1, b2, b3);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_y(input string tag);
    #1;
    check({tag, "_y1"}, {7'b0, y1}, ref1());
    check({tag, "_y8"}, y8, ref8());
  endtask

  // One rising edge: the model registers what the inputs were just before it.
  task automatic edge_check(input string tag);
    logic [7:0] n1, n8;
    n1 = ref1();
    n8 = ref8();
    @(posedge clk);
    if (rst) begin
      exp_q1 = 8'h00;
      exp_q8 = 8'h00;
    end else if (!HasEn || en) begin
      exp_q1 = n1;
      exp_q8 = n8;
    end
    #1;
    check({tag, "_yq1"}, {7'b0, y1_q}, exp_q1);
    check({tag, "_yq8"}, y8_q, exp_q8);
  endtask

  initial begin
    exp_q1 = 8'h00;
    exp_q8 = 8'h00;
    rst = 1'b1;
    en  = 1'b1;
    sel = 2'd0;
    {a0, a1, a2, a3} = 4'b1010;
    b0 = 8'hA5; b1 = 8'h3C; b2 = 8'hFF; b3 = 8'h00;

    // Reset: y_q cleared, y keeps following the inputs.
    for (int i = 0; i < 2; i++) begin
      edge_check("rst");
      check("rst_y1", {7'b0, y1}, 8'h01);
      check("rst_y8", y8, 8'hA5);
    end

    // First edge out of reset loads immediately, then step sel 0..3.
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      check_y("dir");
      edge_check("dir");
    end

    // Combinational path only: change sel mid-cycle, no edge in between.
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      check("comb_y1", {7'b0, y1}, (s % 2 == 0) ? 8'h01 : 8'h00);
      check("comb_y8", y8, ref8());
      #1;
    end

    // Randomized traffic with occasional resets and enable toggles.
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      sel = 2'($urandom);
      {a0, a1, a2, a3} = 4'($urandom);
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
      rst = ($urandom_range(0, 7) == 0);
      en  = ($urandom_range(0, 2) != 0);
      check_y("rnd");
      edge_check("rnd");
    end

`ifdef MUX4_TO_1_HOLD_EN
    // Hold: load 1, then en=0 with y=0 for three edges, then release.
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    sel = 2'd0;
    {a0, a1, a2, a3} = 4'b1010;
    b0 = 8'hA5; b1 = 8'h3C; b2 = 8'hFF; b3 = 8'h00;
    edge_check("hold_load");
    en  = 1'b0;
    sel = 2'd1;
    for (int i = 0; i < 3; i++) begin
      edge_check("hold");
      check("hold_fixed", {7'b0, y1_q}, 8'h01);
    end
    en = 1'b1;
    edge_check("hold_rel");
    check("hold_rel_fixed", {7'b0, y1_q}, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux4_to_1.md
MUX4_TO_1 -- requirements
Module: mux4_to_1

Interface
REQ-001 Parameter: WIDTH, default 1, bit width of each data input and of both outputs.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: i0  input  WIDTH  data input selected when sel=2'b00.
REQ-005 Port: i1  input  WIDTH  data input selected when sel=2'b01.
REQ-006 Port: i2  input  WIDTH  data input selected when sel=2'b10.
REQ-007 Port: i3  input  WIDTH  data input selected when sel=2'b11.
REQ-008 Port: sel  input  2  select code.
REQ-009 Port: y  output  WIDTH  combinational mux output.
REQ-010 Port: y_q  output  WIDTH  registered copy of y.
REQ-011 Port (only with MUX4_TO_1_HOLD_EN): en  input  1  register update enable.

Function
REQ-012 y SHALL equal i0/i1/i2/i3 for sel = 0/1/2/3, with zero clock latency (pure combinational path).
REQ-013 y SHALL be built as two levels of 2:1 muxes: level 1 picks i0/i1 and i2/i3 by sel[0]; level 2 picks between those results by sel[1].
REQ-014 y SHALL respond to any input change in the same delta cycle, independent of clk and rst.
REQ-015 y_q SHALL take the value of y sampled at each rising clk edge (one-cycle latency).
REQ-016 Selection SHALL be bitwise across WIDTH; no arithmetic, no width extension or truncation.
REQ-017 Simultaneous sel and data changes SHALL yield y = new data at new sel; y_q reflects values present at the sampling edge.
REQ-018 With sel containing X/Z in simulation, y is don't-care; no internal state is corrupted beyond y_q for that cycle.

Reset
REQ-019 When rst=1 at a rising clk edge, y_q SHALL become all zeros on that edge.
REQ-020 rst SHALL take priority over en and over data capture.
REQ-021 rst SHALL NOT affect y; y stays combinational during reset.
REQ-022 The first rising edge with rst=0 SHALL load y_q normally, with no extra latency.

Configuration
REQ-023 Macro MUX4_TO_1_HOLD_EN: when defined, port en exists; y_q loads y only on edges with en=1 and holds otherwise (reset still applies).
REQ-024 When MUX4_TO_1_HOLD_EN is undefined, port en is absent and y_q loads y on every non-reset edge.

Structure
REQ-025 A shared package mux4_to_1_pkg SHALL hold the select codes SEL_I0=2'b00, SEL_I1=2'b01, SEL_I2=2'b10, SEL_I3=2'b11, and the default WIDTH constant.
REQ-026 One sub-module mux2_to_1 (parameter WIDTH; ports a, b, s, y; y = s ? b : a) SHALL be instantiated three times to form REQ-013.
REQ-027 The y_q register SHALL reside in mux4_to_1, not in the sub-module.

Verification
REQ-028 WIDTH=1, i0=1 i1=0 i2=1 i3=0, sel stepped 0,1,2,3 every 10 ns -> y = 1,0,1,0 within each step, with no clock needed.
REQ-029 Same data, clock running, rst=0 -> y_q equals the previous-edge y (e.g., sel 0->1 gives y_q 1 then 0 one cycle later).
REQ-030 rst=1 for 2 cycles with i0=1, sel=0 -> y_q=0 during reset and y=1 throughout; y_q=1 on the first edge after rst drops.
REQ-031 WIDTH=8, i0=8'hA5 i1=8'h3C i2=8'hFF i3=8'h00, all four sel values -> y = A5, 3C, FF, 00 exactly.
REQ-032 With MUX4_TO_1_HOLD_EN: y_q=1 loaded, then en=0 and sel=1 (y=0) for 3 edges -> y_q stays 1; en=1 -> y_q=0 on the next edge.
